// File: rtl/simon_pattern_store.sv
// simon_pattern_store
//   Holds the Simon game's growing pattern sequence. It checks switch
//   patterns for legality and appends accepted ones. On command it replays
//   the stored sequence one entry per step. It also compares the player's
//   repeated entries against the stored sequence.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous reset, active-low
//   sw_pattern     current switch pattern
//   level          0 = easy (exactly one bit set is legal), 1 = hard (any legal)
//   cmd_clear      empty the sequence (same effect as reset on state/outputs)
//   cmd_store      append sw_pattern if it is legal and the store is not full
//   cmd_play_start rewind the shared pointer to entry 0 and present that entry
//   cmd_play_step  advance playback to the next entry
//   cmd_check      compare sw_pattern against the entry at the pointer
//   pattern_legal  combinational legality of sw_pattern under level
//   store_ack      one-cycle pulse: the previous cycle's store was accepted
//   play_pattern   registered pattern at the playback pointer
//   play_valid     play_pattern holds a real entry
//   play_last      play_pattern is the final stored entry
//   check_done     one-cycle pulse: the check result is valid
//   check_match    the last check matched
//   check_last     the last check was against the final entry
//   count          number of stored patterns
//   full           count == DEPTH
//
// Command priority: clear > store > play_start > check > play_step.
module simon_pattern_store #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sw_pattern,
  input  logic                     level,
  input  logic                     cmd_clear,
  input  logic                     cmd_store,
  input  logic                     cmd_play_start,
  input  logic                     cmd_play_step,
  input  logic                     cmd_check,
  output logic                     pattern_legal,
  output logic                     store_ack,
  output logic [WIDTH-1:0]         play_pattern,
  output logic                     play_valid,
  output logic                     play_last,
  output logic                     check_done,
  output logic                     check_match,
  output logic                     check_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_TWO  = {{(CW-2){1'b0}}, 2'b10};
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};

  // True when exactly one bit of the pattern is set (all-zero is rejected).
  function automatic logic is_one_hot(input logic [WIDTH-1:0] p);
    logic seen;
    logic dup;
    seen = 1'b0;
    dup  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (p[i]) begin
        if (seen) begin
          dup = 1'b1;
        end else begin
          seen = 1'b1;
        end
      end
    end
    return seen && !dup;
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic [AW-1:0]    ptr_r;
  logic             store_ack_r;
  logic [WIDTH-1:0] play_pattern_r;
  logic             play_valid_r;
  logic             play_last_r;
  logic             check_done_r;
  logic             check_match_r;
  logic             check_last_r;

  logic [CW-1:0]    count_n_s;
  logic [AW-1:0]    ptr_n_s;
  logic             store_ack_n_s;
  logic [WIDTH-1:0] play_pattern_n_s;
  logic             play_valid_n_s;
  logic             play_last_n_s;
  logic             check_done_n_s;
  logic             check_match_n_s;
  logic             check_last_n_s;
  logic             wr_en_s;

  logic             legal_s;
  logic             full_s;
  logic [AW-1:0]    ptr_inc_s;
  logic             match_s;
  logic             at_last_s;

  assign legal_s   = level | is_one_hot(sw_pattern);
  assign full_s    = (count_r == CNT_FULL);
  assign ptr_inc_s = ptr_r + PTR_ONE;
  // An empty store never matches, even though mem[0] may hold stale data.
  assign match_s   = (count_r != CNT_ZERO) && (sw_pattern == mem_r[ptr_r]);
  // With count == 0, count-1 is all ones and can never equal a zero-extended ptr.
  assign at_last_s = ({1'b0, ptr_r} == (count_r - CNT_ONE));

  // Next-state decode with strict command priority.
  always_comb begin
    count_n_s        = count_r;
    ptr_n_s          = ptr_r;
    store_ack_n_s    = 1'b0;
    play_pattern_n_s = play_pattern_r;
    play_valid_n_s   = play_valid_r;
    play_last_n_s    = play_last_r;
    check_done_n_s   = 1'b0;
    check_match_n_s  = check_match_r;
    check_last_n_s   = check_last_r;
    wr_en_s          = 1'b0;

    if (cmd_clear) begin
      count_n_s        = CNT_ZERO;
      ptr_n_s          = PTR_ZERO;
      play_pattern_n_s = PAT_ZERO;
      play_valid_n_s   = 1'b0;
      play_last_n_s    = 1'b0;
      check_match_n_s  = 1'b0;
      check_last_n_s   = 1'b0;
    end else if (cmd_store) begin
      play_valid_n_s = 1'b0;
      if (legal_s && !full_s) begin
        wr_en_s       = 1'b1;
        count_n_s     = count_r + CNT_ONE;
        store_ack_n_s = 1'b1;
      end else begin
        store_ack_n_s = 1'b0;
      end
    end else if (cmd_play_start) begin
      ptr_n_s = PTR_ZERO;
      if (count_r != CNT_ZERO) begin
        play_pattern_n_s = mem_r[PTR_ZERO];
        play_valid_n_s   = 1'b1;
        play_last_n_s    = (count_r == CNT_ONE);
      end else begin
        play_pattern_n_s = PAT_ZERO;
        play_valid_n_s   = 1'b0;
        play_last_n_s    = 1'b0;
      end
    end else if (cmd_check) begin
      check_done_n_s  = 1'b1;
      check_match_n_s = match_s;
      check_last_n_s  = at_last_s;
      play_valid_n_s  = 1'b0;
      if (match_s && !at_last_s) begin
        ptr_n_s = ptr_inc_s;
      end else begin
        ptr_n_s = ptr_r;
      end
    end else if (cmd_play_step) begin
      // Stepping stops at the final entry, so ptr_inc_s is always < count here.
      if (play_valid_r && !play_last_r) begin
        ptr_n_s          = ptr_inc_s;
        play_pattern_n_s = mem_r[ptr_inc_s];
        play_last_n_s    = (({1'b0, ptr_r} + CNT_TWO) == count_r);
      end else begin
        ptr_n_s = ptr_r;
      end
    end else begin
      ptr_n_s = ptr_r;
    end
  end

  // Control and output registers; reset overrides any same-cycle command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r        <= CNT_ZERO;
      ptr_r          <= PTR_ZERO;
      store_ack_r    <= 1'b0;
      play_pattern_r <= PAT_ZERO;
      play_valid_r   <= 1'b0;
      play_last_r    <= 1'b0;
      check_done_r   <= 1'b0;
      check_match_r  <= 1'b0;
      check_last_r   <= 1'b0;
    end else begin
      count_r        <= count_n_s;
      ptr_r          <= ptr_n_s;
      store_ack_r    <= store_ack_n_s;
      play_pattern_r <= play_pattern_n_s;
      play_valid_r   <= play_valid_n_s;
      play_last_r    <= play_last_n_s;
      check_done_r   <= check_done_n_s;
      check_match_r  <= check_match_n_s;
      check_last_r   <= check_last_n_s;
    end
  end

  // Pattern array write; contents survive reset but are unreachable at count 0.
  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      mem_r[count_r[AW-1:0]] <= sw_pattern;
    end
  end

  assign pattern_legal = legal_s;
  assign store_ack     = store_ack_r;
  assign play_pattern  = play_pattern_r;
  assign play_valid    = play_valid_r;
  assign play_last     = play_last_r;
  assign check_done    = check_done_r;
  assign check_match   = check_match_r;
  assign check_last    = check_last_r;
  assign count         = count_r;
  assign full          = full_s;

endmodule

// File: tb/tb_simon_pattern_store.sv
// tb_simon_pattern_store
//   Self-checking bench for simon_pattern_store (WIDTH=4, DEPTH=4).
//   Each scenario builds a stimulus table with expected outputs. Each
//   expectation is queued when its command is driven and popped and compared
//   one edge later.
module tb_simon_pattern_store;

  logic       clk;
  logic       rst;
  logic [3:0] sw_pattern;
  logic       level;
  logic       cmd_clear;
  logic       cmd_store;
  logic       cmd_play_start;
  logic       cmd_play_step;
  logic       cmd_check;
  logic       pattern_legal;
  logic       store_ack;
  logic [3:0] play_pattern;
  logic       play_valid;
  logic       play_last;
  logic       check_done;
  logic       check_match;
  logic       check_last;
  logic [2:0] count;
  logic       full;

  int errors = 0;
  int checks = 0;

  // command encoding {clear, store, play_start, check, step}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_CLR  = 5'b10000;
  localparam logic [4:0] C_ST   = 5'b01000;
  localparam logic [4:0] C_PS   = 5'b00100;
  localparam logic [4:0] C_CK   = 5'b00010;
  localparam logic [4:0] C_SP   = 5'b00001;

  typedef struct {
    logic        rstn;
    logic [4:0]  cmd;
    logic [3:0]  sw;
    logic        lvl;
    logic [13:0] exp;
  } stim_t;

  logic [13:0] sb[$];
  logic [13:0] obs;

  // {ack, pattern[4], valid, last, done, match, clast, count[3], full}
  assign obs = {store_ack, play_pattern, play_valid, play_last, check_done,
                check_match, check_last, count, full};

  simon_pattern_store #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sw_pattern(sw_pattern), .level(level),
    .cmd_clear(cmd_clear), .cmd_store(cmd_store), .cmd_play_start(cmd_play_start),
    .cmd_play_step(cmd_play_step), .cmd_check(cmd_check),
    .pattern_legal(pattern_legal), .store_ack(store_ack),
    .play_pattern(play_pattern), .play_valid(play_valid), .play_last(play_last),
    .check_done(check_done), .check_match(check_match), .check_last(check_last),
    .count(count), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] ex(input logic ack, input logic [3:0] pat,
      input logic pv, input logic pl, input logic cd, input logic cm,
      input logic cl, input logic [2:0] cnt, input logic fl);
    return {ack, pat, pv, pl, cd, cm, cl, cnt, fl};
  endfunction

  // match/last are only meaningful while check_done is expected high
  function automatic logic [13:0] msk(input logic [13:0] e);
    logic [13:0] m;
    m = 14'h3FFF;
    if (!e[6]) m[5:4] = 2'b00;
    return m;
  endfunction

  function automatic stim_t mk(input logic rstn, input logic [4:0] cmd,
      input logic [3:0] sw, input logic lvl, input logic [13:0] e);
    stim_t s;
    s.rstn = rstn; s.cmd = cmd; s.sw = sw; s.lvl = lvl; s.exp = e;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rstn;
    {cmd_clear, cmd_store, cmd_play_start, cmd_check, cmd_play_step} = s.cmd;
    sw_pattern = s.sw;
    level = s.lvl;
  endtask

  task automatic idle();
    rst = 1'b1;
    {cmd_clear, cmd_store, cmd_play_start, cmd_check, cmd_play_step} = C_NONE;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    drive(mk(1'b0, C_NONE, 4'b0000, 1'b0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    sb.push_back(ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset: got %b expected %b", obs, e);
    end
    idle();
  endtask

  task automatic test_legality();
    logic [3:0] sw_t [5]  = '{4'b0101, 4'b0100, 4'b0000, 4'b0101, 4'b1111};
    logic       lv_t [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      sw_pattern = sw_t[i];
      level = lv_t[i];
      #1;
      checks++;
      if (pattern_legal !== exp_t[i]) begin
        errors++;
        $display("FAIL legality[%0d]: got %b expected %b", i, pattern_legal, exp_t[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_playback();
    stim_t s[$];
    logic [13:0] e;
    s.push_back(mk(1, C_ST, 4'b0001, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd1, 0)));
    s.push_back(mk(1, C_ST, 4'b0010, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd2, 0)));
    s.push_back(mk(1, C_ST, 4'b1000, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(1, C_PS, 4'b0000, 0, ex(0, 4'b0001, 1, 0, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(1, C_SP, 4'b0000, 0, ex(0, 4'b0010, 1, 0, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(1, C_SP, 4'b0000, 0, ex(0, 4'b1000, 1, 1, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(1, C_SP, 4'b0000, 0, ex(0, 4'b1000, 1, 1, 0, 0, 0, 3'd3, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs & msk(e)) !== (e & msk(e))) begin
        errors++;
        $display("FAIL store_playback[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle();
  endtask

  task automatic test_illegal_full();
    stim_t s[$];
    logic [13:0] e;
    s.push_back(mk(1, C_CLR, 4'b0000, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_ST, 4'b0011, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_ST, 4'b0011, 1, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd1, 0)));
    s.push_back(mk(1, C_ST, 4'b0010, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd2, 0)));
    s.push_back(mk(1, C_ST, 4'b0100, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(1, C_ST, 4'b1000, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd4, 1)));
    s.push_back(mk(1, C_ST, 4'b0001, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd4, 1)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs & msk(e)) !== (e & msk(e))) begin
        errors++;
        $display("FAIL illegal_full[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle();
  endtask

  task automatic test_check();
    stim_t s[$];
    logic [13:0] e;
    s.push_back(mk(1, C_CLR, 4'b0000, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_ST, 4'b0001, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd1, 0)));
    s.push_back(mk(1, C_ST, 4'b0010, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd2, 0)));
    s.push_back(mk(1, C_PS, 4'b0000, 0, ex(0, 4'b0001, 1, 0, 0, 0, 0, 3'd2, 0)));
    s.push_back(mk(1, C_CK, 4'b0001, 0, ex(0, 4'b0001, 0, 0, 1, 1, 0, 3'd2, 0)));
    s.push_back(mk(1, C_CK, 4'b0100, 0, ex(0, 4'b0001, 0, 0, 1, 0, 1, 3'd2, 0)));
    s.push_back(mk(1, C_CK, 4'b0010, 0, ex(0, 4'b0001, 0, 0, 1, 1, 1, 3'd2, 0)));
    s.push_back(mk(1, C_CK, 4'b0010, 0, ex(0, 4'b0001, 0, 0, 1, 1, 1, 3'd2, 0)));
    s.push_back(mk(1, C_NONE, 4'b0000, 0, ex(0, 4'b0001, 0, 0, 0, 0, 0, 3'd2, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs & msk(e)) !== (e & msk(e))) begin
        errors++;
        $display("FAIL check[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle();
  endtask

  task automatic test_priority_clear();
    stim_t s[$];
    logic [13:0] e;
    s.push_back(mk(1, C_CLR | C_ST, 4'b0001, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_PS, 4'b0000, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_CK, 4'b0001, 0, ex(0, 4'h0, 0, 0, 1, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_ST | C_PS, 4'b0100, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd1, 0)));
    s.push_back(mk(1, C_PS | C_CK, 4'b0100, 0, ex(0, 4'b0100, 1, 1, 0, 0, 0, 3'd1, 0)));
    s.push_back(mk(1, C_CK | C_SP, 4'b0100, 0, ex(0, 4'b0100, 0, 1, 1, 1, 1, 3'd1, 0)));
    s.push_back(mk(1, C_SP, 4'b0000, 0, ex(0, 4'b0100, 0, 1, 0, 0, 0, 3'd1, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs & msk(e)) !== (e & msk(e))) begin
        errors++;
        $display("FAIL priority_clear[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    stim_t s[$];
    logic [13:0] e;
    s.push_back(mk(1, C_CLR, 4'b0000, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_ST, 4'b0001, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd1, 0)));
    s.push_back(mk(1, C_ST, 4'b0010, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd2, 0)));
    s.push_back(mk(1, C_ST, 4'b0100, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(1, C_PS, 4'b0000, 0, ex(0, 4'b0001, 1, 0, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(1, C_SP, 4'b0000, 0, ex(0, 4'b0010, 1, 0, 0, 0, 0, 3'd3, 0)));
    s.push_back(mk(0, C_SP, 4'b0000, 0, ex(0, 4'h0, 0, 0, 0, 0, 0, 3'd0, 0)));
    s.push_back(mk(1, C_ST, 4'b1000, 0, ex(1, 4'h0, 0, 0, 0, 0, 0, 3'd1, 0)));
    s.push_back(mk(1, C_CK, 4'b1000, 0, ex(0, 4'h0, 0, 0, 1, 1, 1, 3'd1, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back(s[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ((obs & msk(e)) !== (e & msk(e))) begin
        errors++;
        $display("FAIL mid_reset[%0d]: got %b expected %b", i, obs, e);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    sw_pattern = 4'b0000;
    level = 1'b0;
    {cmd_clear, cmd_store, cmd_play_start, cmd_check, cmd_play_step} = C_NONE;
    #2;
    test_reset();
    test_legality();
    test_store_playback();
    test_illegal_full();
    test_check();
    test_priority_clear();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
